// File: rtl/ext_adc_arb_pkg.sv
// Shared definitions for the external ADC arbiter: FSM encoding and ADC data width.
package ext_adc_arb_pkg;

  localparam int ADC_W = 16;

  typedef enum logic [1:0] {
    stIdle    = 2'b00,
    stConvert = 2'b01,
    stRelease = 2'b10
  } state_t;

endpackage

// File: rtl/ext_adc_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit after Last_i, wrapping modulo NumReq.
module rr_pick #(
  parameter int NumReq   = 2,
  parameter int IdxWidth = 3
) (
  input  logic [NumReq-1:0]   Req_i,
  input  logic [IdxWidth-1:0] Last_i,
  output logic [IdxWidth-1:0] Idx_o,
  output logic                Any_o
);

  int cand;

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    Idx_o = '0;
    Any_o = 1'b0;
    cand  = 0;
    for (int k = NumReq; k >= 1; k--) begin
      cand = (int'(Last_i) + k) % NumReq;
      if (Req_i[cand]) begin
        Idx_o = IdxWidth'(cand);
        Any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_adc_arbiter.sv
// Round-robin sharing of one external ADC conversion port between NumReq requesters.
// Optional watchdog abort with interrupt is built when EXT_ADC_ARB_TIMEOUT_EN is defined.
module ext_adc_arbiter
  import ext_adc_arb_pkg::*;
#(
  parameter int NumReq   = 2,
  parameter int IdxWidth = 3
) (
  input  logic               Clk_i,
  input  logic               Reset_n_i,
  input  logic               Enable_i,
  input  logic [NumReq-1:0]  Req_i,
  output logic [NumReq-1:0]  Grant_o,
  output logic [NumReq-1:0]  Done_o,
  output logic [ADC_W-1:0]   Value_o,
  output logic               AdcStart_o,
  input  logic               AdcDone_i,
  input  logic [ADC_W-1:0]   AdcValue_i,
  input  logic [15:0]        TimeoutPreset_i,
  output logic               TimeoutIrq_o
);

  state_t              state_q, state_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [IdxWidth-1:0] last_q, last_d;
  logic                ok_q, ok_d;
  logic [ADC_W-1:0]    value_q, value_d;
  logic [IdxWidth-1:0] pick_idx;
  logic                pick_any;
  logic [NumReq-1:0]   idx_onehot;

`ifdef EXT_ADC_ARB_TIMEOUT_EN
  logic [15:0]         timer_q, timer_d;
`else
  logic                unused_preset;
  assign unused_preset = ^TimeoutPreset_i;
`endif

  rr_pick #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr_pick (
    .Req_i  (Req_i),
    .Last_i (last_q),
    .Idx_o  (pick_idx),
    .Any_o  (pick_any)
  );

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= stIdle;
      idx_q   <= '0;
      last_q  <= IdxWidth'(NumReq - 1);
      ok_q    <= 1'b0;
      value_q <= '0;
`ifdef EXT_ADC_ARB_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      value_q <= value_d;
`ifdef EXT_ADC_ARB_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ok_d    = ok_q;
    value_d = value_q;
`ifdef EXT_ADC_ARB_TIMEOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      stIdle: begin
        if (Enable_i && pick_any) begin
          idx_d   = pick_idx;
          last_d  = pick_idx;
          state_d = stConvert;
`ifdef EXT_ADC_ARB_TIMEOUT_EN
          timer_d = TimeoutPreset_i;
`endif
        end
      end
      stConvert: begin
        // Completion is tested first so it wins over a simultaneous expiry.
        if (AdcDone_i) begin
          value_d = AdcValue_i;
          ok_d    = 1'b1;
          state_d = stRelease;
        end
`ifdef EXT_ADC_ARB_TIMEOUT_EN
        else if (timer_q != 16'd0) begin
          if (timer_q == 16'd1) begin
            ok_d    = 1'b0;
            state_d = stRelease;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
`endif
      end
      stRelease: state_d = stIdle;
      default:   state_d = stIdle;
    endcase
  end

  assign idx_onehot = {{(NumReq-1){1'b0}}, 1'b1} << idx_q;

  assign Grant_o    = (state_q == stConvert) ? idx_onehot : '0;
  assign AdcStart_o = (state_q == stConvert);
  assign Done_o     = (state_q == stRelease && ok_q) ? idx_onehot : '0;
  assign Value_o    = value_q;

`ifdef EXT_ADC_ARB_TIMEOUT_EN
  assign TimeoutIrq_o = (state_q == stRelease) && !ok_q;
`else
  assign TimeoutIrq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ext_adc_arbiter.sv
// Scoreboard bench for ext_adc_arbiter: random and directed conversions against a transaction-level model.
module tb_ext_adc_arbiter;

  localparam int N  = 2;
  localparam int IW = 3;
`ifdef EXT_ADC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Enable_i;
  logic [N-1:0]  Req_i;
  logic [N-1:0]  Grant_o;
  logic [N-1:0]  Done_o;
  logic [15:0]   Value_o;
  logic          AdcStart_o;
  logic          AdcDone_i;
  logic [15:0]   AdcValue_i;
  logic [15:0]   TimeoutPreset_i;
  logic          TimeoutIrq_o;

  ext_adc_arbiter #(.NumReq(N), .IdxWidth(IW)) dut (
    .Clk_i           (clk),
    .Reset_n_i       (rst_n),
    .Enable_i        (Enable_i),
    .Req_i           (Req_i),
    .Grant_o         (Grant_o),
    .Done_o          (Done_o),
    .Value_o         (Value_o),
    .AdcStart_o      (AdcStart_o),
    .AdcDone_i       (AdcDone_i),
    .AdcValue_i      (AdcValue_i),
    .TimeoutPreset_i (TimeoutPreset_i),
    .TimeoutIrq_o    (TimeoutIrq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] done;
    logic         irq;
    logic [15:0]  val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          last_model;
  logic [15:0] model_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: first requester with a set bit after the last winner, modulo N.
  function automatic int rr_model(input logic [N-1:0] mask, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (mask[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  // Monitor: every done or irq presentation must match the oldest expected outcome.
  always @(negedge clk) begin
    if (rst_n && (Done_o != '0 || TimeoutIrq_o)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=%0h Irq=%0b with nothing expected at %0t", Done_o, TimeoutIrq_o, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("done", 32'(Done_o), 32'(mon_e.done));
        check("irq", 32'(TimeoutIrq_o), 32'(mon_e.irq));
        check("value", 32'(Value_o), 32'(mon_e.val));
      end
    end
  end

  // Called at a negedge with the DUT idle. d=0 means the ADC never answers.
  task automatic do_conv(input logic [N-1:0] mask, input int d, input int preset,
                         input logic [15:0] v, input bit drop, input bit en_drop, input bit hold);
    int           idx;
    int           len;
    int           hi;
    bit           to;
    logic [N-1:0] g;
    exp_t         e;
    Req_i           = mask;
    TimeoutPreset_i = 16'(preset);
    idx        = rr_model(mask, last_model);
    last_model = idx;
    g          = '0;
    g[idx]     = 1'b1;
    to  = TO_EN && (preset != 0) && (d == 0 || d > preset);
    len = to ? preset : d;
    if (to) begin
      e.done = '0; e.irq = 1'b1; e.val = model_val;
    end else begin
      e.done = g;  e.irq = 1'b0; e.val = v;
    end
    sb_q.push_back(e);
    hi = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == 1) check("grant", 32'(Grant_o), 32'(g));
      if (AdcStart_o && Grant_o == g) hi++;
      if (i == 1 && drop) Req_i[idx] = 1'b0;
      if (i == 1 && en_drop) Enable_i = 1'b0;
      if (i == len && !to) begin
        AdcDone_i  = 1'b1;
        AdcValue_i = v;
      end
    end
    @(negedge clk);
    AdcDone_i = 1'b0;
    check("start_len", 32'(hi), 32'(len));
    check("release", {31'd0, AdcStart_o} | 32'(Grant_o), 32'd0);
    if (!to) model_val = v;
    if (!hold) Req_i = '0;
    @(negedge clk);
    check("gap", 32'(AdcStart_o), 32'd0);
    $display("conv mask=%b idx=%0d len=%0d preset=%0d timeout=%0b value=%h", mask, idx, len, preset, to, e.val);
  endtask

  initial begin
    logic [N-1:0] m;
    rst_n = 1'b0; Enable_i = 1'b0; Req_i = '0; AdcDone_i = 1'b0;
    AdcValue_i = '0; TimeoutPreset_i = '0;
    last_model = N - 1;
    model_val  = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(Grant_o), 32'd0);
    check("rst_done", 32'(Done_o), 32'd0);
    check("rst_start", 32'(AdcStart_o), 32'd0);
    check("rst_irq", 32'(TimeoutIrq_o), 32'd0);
    check("rst_value", 32'(Value_o), 32'd0);
    rst_n = 1'b1;
    Enable_i = 1'b1;
    @(negedge clk);

    do_conv(2'b01, 5, 0, 16'h1234, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_conv(2'b11, 3, 0, 16'($urandom), 0, 0, 1);
    Req_i = '0;
    @(negedge clk);

    do_conv(2'b10, 100, 0, 16'($urandom), 0, 0, 0);
    do_conv(2'b01, 12, 10, 16'($urandom), 0, 0, 0);
`ifdef EXT_ADC_ARB_TIMEOUT_EN
    do_conv(2'b01, 0, 10, 16'h5555, 0, 0, 0);
    do_conv(2'b01, 4, 4, 16'h4444, 0, 0, 0);
    do_conv(2'b10, 3, 10, 16'h3333, 0, 0, 0);
`endif
    do_conv(2'b10, 6, 0, 16'hA5A5, 1, 0, 0);

    // Enable dropped mid-conversion: conversion finishes, nothing new is granted.
    do_conv(2'b11, 4, 0, 16'($urandom), 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      AdcDone_i  = (i % 2 == 0);
      AdcValue_i = 16'($urandom);
      @(negedge clk);
      check("en_block", {31'd0, AdcStart_o} | 32'(Grant_o), 32'd0);
      check("idle_value", 32'(Value_o), 32'(model_val));
    end
    AdcDone_i = 1'b0;
    Req_i = '0;
    Enable_i = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      do m = N'($urandom); while (m == '0);
      do_conv(m, $urandom_range(1, 12), $urandom_range(0, 10), 16'($urandom),
              bit'($urandom_range(0, 1)), 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a conversion.
    do_conv(2'b01, 2, 0, 16'hBEEF, 0, 0, 0);
    Req_i = 2'b10;
    @(negedge clk);
    check("pre_rst_grant", 32'(Grant_o), 32'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(Grant_o), 32'd0);
    check("arst_start", 32'(AdcStart_o), 32'd0);
    check("arst_done", 32'(Done_o), 32'd0);
    check("arst_irq", 32'(TimeoutIrq_o), 32'd0);
    check("arst_value", 32'(Value_o), 32'd0);
    Req_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last_model = N - 1;
    model_val  = '0;
    do_conv(2'b11, 2, 0, 16'($urandom), 0, 0, 0);

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
